// File: rtl/twiddle_mult_if.sv
// twiddle_mult_if
//   Handshake and data bundle for the twiddle-factor complex multiplier.
//   master : upstream/downstream side (drives samples, out_ready, ovf_clr)
//   slave  : the multiplier (drives in_ready, results and the overflow flag)
//   Signals:
//     in_valid/in_ready          input sample handshake
//     data_r/data_i              data sample, MULT_WIDTH signed
//     twdl_r/twdl_i              twiddle factor, TWIDDLE_WIDTH signed
//     conj, gain, round_en       per-sample controls
//     out_valid/out_ready        output sample handshake
//     out_r/out_i                result, OUTPUT_WIDTH signed
//     ovf, ovf_clr               sticky overflow flag and its clear
`timescale 1ns/1ps
interface twiddle_mult_if #(
  parameter int MULT_WIDTH    = 16,
  parameter int TWIDDLE_WIDTH = 16,
  parameter int OUTPUT_WIDTH  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [MULT_WIDTH-1:0]    data_r;
  logic [MULT_WIDTH-1:0]    data_i;
  logic [TWIDDLE_WIDTH-1:0] twdl_r;
  logic [TWIDDLE_WIDTH-1:0] twdl_i;
  logic                     conj;
  logic                     gain;
  logic                     round_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUTPUT_WIDTH-1:0]  out_r;
  logic [OUTPUT_WIDTH-1:0]  out_i;
  logic                     ovf;
  logic                     ovf_clr;

  modport master (
    output in_valid, data_r, data_i, twdl_r, twdl_i, conj, gain, round_en,
           out_ready, ovf_clr,
    input  in_ready, out_valid, out_r, out_i, ovf
  );

  modport slave (
    input  in_valid, data_r, data_i, twdl_r, twdl_i, conj, gain, round_en,
           out_ready, ovf_clr,
    output in_ready, out_valid, out_r, out_i, ovf
  );
endinterface

// File: rtl/twiddle_mult_pipe.sv
// twiddle_mult_pipe
//   Pipelined twiddle-factor complex multiplier for the FFT butterfly datapath.
//   out = data * twdl, or data * conj(twdl) when conj is set, with optional x2
//   gain, truncate or round-half-up, and a sticky overflow flag.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous reset, active low
//     bus    twiddle_mult_if.slave (sample handshake, controls, results, ovf)
//   Build option:
//     TWIDDLE_MULT_SAT_EN  defined: overflowing lanes saturate to the signed
//                          output range; undefined: overflowing lanes wrap.
//                          ovf is flagged in both builds.
//   Pipeline (PIPE_STAGES registers, 3..6):
//     stage 1  input samples and controls
//     stage 2  four partial products
//     stage 3  sum/difference, round, slice, overflow detect
//     4..N     plain delay
`timescale 1ns/1ps
module twiddle_mult_pipe #(
  parameter int MULT_WIDTH    = 16,
  parameter int TWIDDLE_WIDTH = 16,
  parameter int OUTPUT_WIDTH  = 16,
  parameter int PIPE_STAGES   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  twiddle_mult_if.slave   bus
);

  localparam int MW = MULT_WIDTH;
  localparam int TW = TWIDDLE_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int PS = PIPE_STAGES;
  localparam int PW = MW + TW + 1;          // full-precision sum width

  // Slice windows for gain=0 (index 0) and gain=1 (index 1).
  localparam int H0 = MW + TW - 1;
  localparam int L0 = H0 - OW + 1;
  localparam int H1 = H0 - 1;
  localparam int L1 = H1 - OW + 1;

  // Half-LSB of the selected window; zero when the window starts at bit 0.
  localparam logic [PW-1:0] RND0 =
    (L0 > 0) ? (PW'(1) << ((L0 > 0) ? (L0 - 1) : 0)) : '0;
  localparam logic [PW-1:0] RND1 =
    (L1 > 0) ? (PW'(1) << ((L1 > 0) ? (L1 - 1) : 0)) : '0;

  localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

  typedef struct packed {
    logic          ovf;
    logic [OW-1:0] q;
  } lane_t;

  // Round, slice and overflow-check one lane. Overflow means the rounded sum
  // does not fit the signed range whose sign bit is the top of the window.
  function automatic lane_t proc_lane(input logic signed [PW-1:0] p,
                                      input logic g,
                                      input logic rnd);
    logic signed [PW-1:0] pr;
    lane_t                res;
    pr      = p;
    res.ovf = 1'b0;
    res.q   = '0;
    if (g) begin
      if (rnd) pr = pr + RND1;
      res.q   = pr[H1:L1];
      res.ovf = !((&pr[PW-1:H1]) || !(|pr[PW-1:H1]));
    end else begin
      if (rnd) pr = pr + RND0;
      res.q   = pr[H0:L0];
      res.ovf = !((&pr[PW-1:H0]) || !(|pr[PW-1:H0]));
    end
`ifdef TWIDDLE_MULT_SAT_EN
    if (res.ovf) res.q = pr[PW-1] ? OMIN : OMAX;
`endif
    return res;
  endfunction

  // Whole pipe advances together; a stall freezes every stage.
  logic adv;

  // Stage 1
  logic                 s1_v;
  logic signed [MW-1:0] s1_ar, s1_ai;
  logic signed [TW-1:0] s1_br, s1_bi;
  logic                 s1_conj, s1_gain, s1_rnd;

  // Stage 2
  logic                 s2_v;
  logic signed [PW-1:0] pp_rr, pp_ii, pp_ri, pp_ir;
  logic                 s2_gain, s2_rnd;

  // Stage 3 .. PS
  logic                 d_v   [3:PS];
  logic [OW-1:0]        d_r   [3:PS];
  logic [OW-1:0]        d_i   [3:PS];
  logic                 d_ovf [3:PS];

  logic                 ovf_q;

  // Sign-extended operands; the twiddle imaginary part is negated in full
  // width so conj never wraps.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] p_r, p_i;
  lane_t                lane_r, lane_i;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  always_comb begin
    ar_x = {{(PW-MW){s1_ar[MW-1]}}, s1_ar};
    ai_x = {{(PW-MW){s1_ai[MW-1]}}, s1_ai};
    br_x = {{(PW-TW){s1_br[TW-1]}}, s1_br};
    bi_x = {{(PW-TW){s1_bi[TW-1]}}, s1_bi};
    if (s1_conj) bi_x = -bi_x;
  end

  always_comb begin
    p_r    = pp_rr - pp_ii;
    p_i    = pp_ri + pp_ir;
    lane_r = proc_lane(p_r, s2_gain, s2_rnd);
    lane_i = proc_lane(p_i, s2_gain, s2_rnd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_ar   <= '0;
      s1_ai   <= '0;
      s1_br   <= '0;
      s1_bi   <= '0;
      s1_conj <= 1'b0;
      s1_gain <= 1'b0;
      s1_rnd  <= 1'b0;
    end else if (adv) begin
      s1_v    <= bus.in_valid;
      s1_ar   <= bus.data_r;
      s1_ai   <= bus.data_i;
      s1_br   <= bus.twdl_r;
      s1_bi   <= bus.twdl_i;
      s1_conj <= bus.conj;
      s1_gain <= bus.gain;
      s1_rnd  <= bus.round_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      pp_rr   <= '0;
      pp_ii   <= '0;
      pp_ri   <= '0;
      pp_ir   <= '0;
      s2_gain <= 1'b0;
      s2_rnd  <= 1'b0;
    end else if (adv) begin
      s2_v    <= s1_v;
      pp_rr   <= ar_x * br_x;
      pp_ii   <= ai_x * bi_x;
      pp_ri   <= ar_x * bi_x;
      pp_ir   <= ai_x * br_x;
      s2_gain <= s1_gain;
      s2_rnd  <= s1_rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 3; k <= PS; k++) begin
        d_v[k]   <= 1'b0;
        d_r[k]   <= '0;
        d_i[k]   <= '0;
        d_ovf[k] <= 1'b0;
      end
    end else if (adv) begin
      d_v[3]   <= s2_v;
      d_r[3]   <= lane_r.q;
      d_i[3]   <= lane_i.q;
      d_ovf[3] <= lane_r.ovf | lane_i.ovf;
      for (int k = 4; k <= PS; k++) begin
        d_v[k]   <= d_v[k-1];
        d_r[k]   <= d_r[k-1];
        d_i[k]   <= d_i[k-1];
        d_ovf[k] <= d_ovf[k-1];
      end
    end
  end

  // Flag is raised when an overflowing sample leaves the block; a set in the
  // same cycle as ovf_clr takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.out_valid && bus.out_ready && d_ovf[PS]) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.out_valid = d_v[PS];
  assign bus.out_r     = d_r[PS];
  assign bus.out_i     = d_i[PS];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
`timescale 1ns/1ps
module tb_twiddle_mult_pipe;

  localparam int MW = 16;
  localparam int TW = 16;
  localparam int OW = 16;
  localparam int PS = 3;
  localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (OW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twiddle_mult_if #(.MULT_WIDTH(MW), .TWIDDLE_WIDTH(TW), .OUTPUT_WIDTH(OW)) bus ();

  twiddle_mult_pipe #(
    .MULT_WIDTH(MW), .TWIDDLE_WIDTH(TW), .OUTPUT_WIDTH(OW), .PIPE_STAGES(PS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int r;
    int i;
    bit ov;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   exp_ovf = 1'b0;
  bit   held    = 1'b0;
  int   held_r, held_i;
  bit   done    = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact complex product, scaled by 2^gain, floored to the
  // output LSB (after adding half an LSB when rounding), then clamped or wrapped.
  function automatic void ref_lane(input longint p, input bit g, input bit rn,
                                   output int q, output bit ov);
    int     sh;
    longint v;
    sh = MW + TW - OW - int'(g);
    v  = p;
    if (rn && sh > 0) v = v + (longint'(1) << (sh - 1));
    v  = v >>> sh;
    ov = (v > MAXV) || (v < MINV);
    if (ov) begin
`ifdef TWIDDLE_MULT_SAT_EN
      v = (v < 0) ? MINV : MAXV;
`else
      v = v & ((longint'(1) << OW) - 1);
      if (v > MAXV) v = v - (longint'(1) << OW);
`endif
    end
    q = int'(v);
  endfunction

  function automatic exp_t ref_model(input int ar, input int ai, input int br,
                                     input int bi, input bit cj, input bit g,
                                     input bit rn);
    exp_t   e;
    longint bie, pr, pi;
    bit     ovr, ovi;
    bie = cj ? -longint'(bi) : longint'(bi);
    pr  = longint'(ar) * longint'(br) - longint'(ai) * bie;
    pi  = longint'(ar) * bie + longint'(ai) * longint'(br);
    ref_lane(pr, g, rn, e.r, ovr);
    ref_lane(pi, g, rn, e.i, ovi);
    e.ov = ovr | ovi;
    return e;
  endfunction

  // Scoreboard push on every accepted input.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      sb.push_back(ref_model(int'($signed(bus.data_r)), int'($signed(bus.data_i)),
                             int'($signed(bus.twdl_r)), int'($signed(bus.twdl_i)),
                             bus.conj, bus.gain, bus.round_en));
  end

  // Monitor: pops on every output transfer, checks stall hold, in_ready, ovf.
  always @(negedge clk) begin
    exp_t e;
    bit   xfer_ov;
    if (!rst_n) begin
      sb.delete();
      exp_ovf = 1'b0;
      held    = 1'b0;
    end else begin
      xfer_ov = 1'b0;
      chk("ovf", longint'(bus.ovf), longint'(exp_ovf));
      chk("in_ready", longint'(bus.in_ready), longint'(bus.out_ready || !bus.out_valid));
      if (held) begin
        chk("hold_valid", longint'(bus.out_valid), 1);
        chk("hold_r", longint'($signed(bus.out_r)), longint'(held_r));
        chk("hold_i", longint'($signed(bus.out_i)), longint'(held_i));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_r", longint'($signed(bus.out_r)), longint'(e.r));
          chk("out_i", longint'($signed(bus.out_i)), longint'(e.i));
          xfer_ov = e.ov;
        end
      end
      held   = bus.out_valid && !bus.out_ready;
      held_r = int'($signed(bus.out_r));
      held_i = int'($signed(bus.out_i));
      if (xfer_ov) exp_ovf = 1'b1;
      else if (bus.ovf_clr) exp_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input bit cj, input bit g, input bit rn);
    int n;
    bit acc;
    bus.data_r   = 16'(ar);
    bus.data_i   = 16'(ai);
    bus.twdl_r   = 16'(br);
    bus.twdl_i   = 16'(bi);
    bus.conj     = cj;
    bus.gain     = g;
    bus.round_en = rn;
    bus.in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Waits for the next output (out_ready held high) and checks it against
  // fixed values; optionally checks the accept-to-output latency.
  task automatic expect_out(input string name, input int er, input int ei,
                            input bit chk_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    if (!bus.out_valid) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      chk({name, "_r"}, longint'($signed(bus.out_r)), longint'(er));
      chk({name, "_i"}, longint'($signed(bus.out_i)), longint'(ei));
      if (chk_lat) chk({name, "_latency"}, longint'(n), longint'(PS));
    end
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain", longint'(sb.size()), 0);
  endtask

  function automatic int rnd_data();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int rnd_twdl();
    int v;
    v = -32768;
    while (v == -32768) v = int'($urandom_range(0, 65535)) - 32768;
    return v;
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_r    = '0;
    bus.data_i    = '0;
    bus.twdl_r    = '0;
    bus.twdl_i    = '0;
    bus.conj      = 1'b0;
    bus.gain      = 1'b0;
    bus.round_en  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_r", longint'(bus.out_r), 0);
    chk("rst_out_i", longint'(bus.out_i), 0);
    chk("rst_ovf", longint'(bus.ovf), 0);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    tick();

    // Directed values
    send(16384, 0, 16384, 0, 0, 0, 0);
    expect_out("gain_trunc", 4096, 0, 1'b1);
    send(16384, 0, 16384, 0, 0, 1, 0);
    expect_out("gain_x2", 8192, 0, 1'b1);
    send(16384, 0, 2, 0, 0, 0, 0);
    expect_out("trunc", 0, 0, 1'b0);
    send(16384, 0, 2, 0, 0, 0, 1);
    expect_out("round", 1, 0, 1'b0);
    send(0, 16384, 0, 16384, 0, 0, 0);
    expect_out("noconj", -4096, 0, 1'b0);
    send(0, 16384, 0, 16384, 1, 0, 0);
    expect_out("conj", 4096, 0, 1'b0);

    // Overflow, sticky flag, clear
    send(-32768, -32768, 32767, -32767, 0, 1, 0);
`ifdef TWIDDLE_MULT_SAT_EN
    expect_out("ovf_out", -32768, 0, 1'b0);
`else
    expect_out("ovf_out", 2, 0, 1'b0);
`endif
    @(negedge clk);
    chk("ovf_set", longint'(bus.ovf), 1);
    tick();
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", longint'(bus.ovf), 0);
    tick();

    // Backpressure: 8 samples, out_ready low for 4 cycles mid-stream
    fork
      begin
        for (int k = 0; k < 8; k++)
          send(rnd_data(), rnd_data(), rnd_twdl(), rnd_twdl(), k[0], 1'b0, k[1]);
      end
      begin
        repeat (5) tick();
        bus.out_ready = 1'b0;
        repeat (4) tick();
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with 3 samples in flight
    send(1000, 2000, 3000, 4000, 0, 0, 0);
    send(-1000, 2000, 3000, -4000, 1, 0, 1);
    send(5000, -6000, 7000, 8000, 0, 1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", longint'(bus.out_valid), 0);
    chk("midrst_out_r", longint'(bus.out_r), 0);
    repeat (8) tick();

    // Randomized traffic with random backpressure and ovf_clr pulses
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(rnd_data(), rnd_data(), rnd_twdl(), rnd_twdl(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          bus.out_ready = ($urandom_range(0, 9) < 7);
          bus.ovf_clr   = ($urandom_range(0, 19) == 0);
        end
        bus.out_ready = 1'b1;
        bus.ovf_clr   = 1'b0;
      end
    join
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
